// File: rtl/vram_fetch_sequencer.sv
// Video-fetch byte sequencer: picks one byte of a BYTES-wide VRAM word per CAS slot
// and presents it to the gate array, optionally through a blanking delay line.
module vram_fetch_sequencer #(
    parameter int BYTES = 2,
    parameter int DELAY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_n,
    input  logic               ras_n,
    input  logic               cas_n,
    input  logic               shift_en,
    input  logic               de,
    input  logic [8*BYTES-1:0] vram_din,
    output logic [7:0]         vram_d,
    output logic               fetch_strobe,
    output logic [1:0]         byte_idx
);

    localparam int         DEPTH    = (DELAY > 0) ? DELAY : 1;
    localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

    logic       cas_n_q;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [7:0] vram_d_q, vram_d_d;
    logic       fetch_strobe_q;
    logic [7:0] line_q [DEPTH];

    logic       slot;
    logic       advance;
    logic [7:0] cur_byte;
    logic [7:0] push_byte;
    logic [7:0] delayed_byte;

    // Slot = first clk of CAS low in the video phase; advance = CAS rising edge.
    assign slot    = cpu_n & ~ras_n & ~cas_n &  cas_n_q;
    assign advance = cpu_n & ~ras_n &  cas_n & ~cas_n_q;

    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_idx_q == 2'(i)) begin
                cur_byte = vram_din[8*i +: 8];
            end
        end
    end

    assign push_byte = (shift_en & ~de) ? 8'h00 : cur_byte;

    generate
        if (DELAY == 0) begin : g_no_delay
            assign delayed_byte = push_byte;
        end else begin : g_delay
            assign delayed_byte = line_q[DELAY-1];
        end
    endgenerate

    always_comb begin
        byte_idx_d = byte_idx_q;
        if (!cpu_n) begin
            byte_idx_d = 2'd0;
        end else if (advance && (byte_idx_q != LAST_IDX)) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end
    end

    always_comb begin
        vram_d_d = vram_d_q;
        if (slot) begin
            vram_d_d = shift_en ? delayed_byte : cur_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cas_n_q        <= 1'b1;
            byte_idx_q     <= 2'd0;
            vram_d_q       <= 8'h00;
            fetch_strobe_q <= 1'b0;
        end else begin
            cas_n_q        <= cas_n;
            byte_idx_q     <= byte_idx_d;
            vram_d_q       <= vram_d_d;
            fetch_strobe_q <= slot;
        end
    end

    // The line shifts on every slot in both modes so switching modes sees real history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= 8'h00;
            end
        end else if (slot) begin
            line_q[0] <= push_byte;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign vram_d       = vram_d_q;
    assign fetch_strobe = fetch_strobe_q;
    assign byte_idx     = byte_idx_q;

endmodule

// File: tb/tb_vram_fetch_sequencer.sv
// Bench for vram_fetch_sequencer: a 2-byte/1-delay and a 4-byte/2-delay instance
// checked every cycle against a history-log model, plus literal expectations.
module tb_vram_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_n = 1'b1;
    logic        ras_n = 1'b0;
    logic        cas_n = 1'b1;
    logic        shift_en = 1'b0;
    logic        de = 1'b1;
    logic [15:0] din2 = 16'h0000;
    logic [31:0] din4 = 32'h0000_0000;

    logic [7:0]  vd2, vd4;
    logic        st2, st4;
    logic [1:0]  idx2, idx4;

    int n_chk  = 0;
    int n_fail = 0;
    int st_cnt2 = 0;
    int st_cnt4 = 0;

    always #5 clk = ~clk;

    vram_fetch_sequencer #(.BYTES(2), .DELAY(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
        .shift_en(shift_en), .de(de), .vram_din(din2),
        .vram_d(vd2), .fetch_strobe(st2), .byte_idx(idx2)
    );

    vram_fetch_sequencer #(.BYTES(4), .DELAY(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
        .shift_en(shift_en), .de(de), .vram_din(din4),
        .vram_d(vd4), .fetch_strobe(st4), .byte_idx(idx4)
    );

    // Model: outputs derived from a log of every pushed byte; a delay of D slots
    // simply means "the byte pushed D slots ago" (zero before that many pushes).
    logic [7:0]  m_vd  [2];
    logic        m_st  [2];
    int          m_idx [2];
    int          n_push[2];
    logic [7:0]  log_mem[2][256];
    logic        m_casq;
    logic        m_slot, m_adv;
    int          mb, md;
    logic [31:0] mw;
    logic [7:0]  mcur, mpush;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int k = 0; k < 2; k++) begin
                    m_vd[k] = 8'h00; m_st[k] = 1'b0; m_idx[k] = 0; n_push[k] = 0;
                end
                m_casq = 1'b1;
            end else begin
                m_slot = cpu_n && !ras_n && !cas_n && m_casq;
                m_adv  = cpu_n && !ras_n && cas_n && !m_casq;
                for (int k = 0; k < 2; k++) begin
                    mb    = (k == 0) ? 2 : 4;
                    md    = (k == 0) ? 1 : 2;
                    mw    = (k == 0) ? {16'h0000, din2} : din4;
                    mcur  = 8'(mw >> (8 * m_idx[k]));
                    mpush = (shift_en && !de) ? 8'h00 : mcur;
                    m_st[k] = m_slot;
                    if (m_slot) begin
                        if (!shift_en)
                            m_vd[k] = mcur;
                        else if (md == 0)
                            m_vd[k] = mpush;
                        else
                            m_vd[k] = (n_push[k] >= md) ? log_mem[k][(n_push[k] - md) % 256] : 8'h00;
                        log_mem[k][n_push[k] % 256] = mpush;
                        n_push[k]++;
                    end
                    if (!cpu_n)
                        m_idx[k] = 0;
                    else if (m_adv && m_idx[k] < mb - 1)
                        m_idx[k]++;
                end
                m_casq = cas_n;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (st2) st_cnt2++;
            if (st4) st_cnt4++;
            chk("cyc_vd2",  32'(vd2),  32'(m_vd[0]));
            chk("cyc_st2",  32'(st2),  32'(m_st[0]));
            chk("cyc_idx2", 32'(idx2), 32'(m_idx[0]));
            chk("cyc_vd4",  32'(vd4),  32'(m_vd[1]));
            chk("cyc_st4",  32'(st4),  32'(m_st[1]));
            chk("cyc_idx4", 32'(idx4), 32'(m_idx[1]));
        end
    end

    task automatic cas_pulse();
        @(negedge clk) cas_n = 1'b0;
        repeat (2) @(negedge clk);
        cas_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_clear(input int n);
        @(negedge clk) cpu_n = 1'b0;
        repeat (n) @(negedge clk);
        cpu_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk) reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    int s0;

    initial begin
        // 1. Reset held while CAS pulses in the video phase
        repeat (2) @(negedge clk);
        cas_pulse();
        cas_pulse();
        chk("rst_vd",  32'(vd2),  32'h00);
        chk("rst_st",  32'(st_cnt2), 32'd0);
        chk("rst_idx", 32'(idx2), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // 2. Direct mode, saturation on third pulse
        shift_en = 1'b0; din2 = 16'hA55A;
        s0 = st_cnt2;
        cas_pulse(); chk("dir_b0", 32'(vd2), 32'h5A);
        cas_pulse(); chk("dir_b1", 32'(vd2), 32'hA5);
        chk("dir_strobes", 32'(st_cnt2 - s0), 32'd2);
        cas_pulse(); chk("dir_sat", 32'(vd2), 32'hA5);

        // 3. CPU phase: no slot, index cleared
        cpu_n = 1'b0;
        s0 = st_cnt2;
        cas_pulse();
        chk("cpu_hold_vd", 32'(vd2), 32'hA5);
        chk("cpu_no_strobe", 32'(st_cnt2 - s0), 32'd0);
        chk("cpu_idx", 32'(idx2), 32'd0);
        cpu_n = 1'b1; din2 = 16'h1234;
        cas_pulse(); chk("clr_b0", 32'(vd2), 32'h34);
        cas_pulse(); chk("clr_b1", 32'(vd2), 32'h12);

        // 1b. Asynchronous reset mid-word
        cpu_clear(2);
        din2 = 16'h00A5;
        cas_pulse(); chk("pre_rst_vd", 32'(vd2), 32'hA5);
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk("async_rst_vd",  32'(vd2),  32'h00);
        chk("async_rst_idx", 32'(idx2), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 4. Shift mode, DELAY=1, de=1
        shift_en = 1'b1; de = 1'b1; din2 = 16'hA55A;
        cas_pulse(); chk("sh_w0_b0", 32'(vd2), 32'h00);
        cas_pulse(); chk("sh_w0_b1", 32'(vd2), 32'h5A);
        cpu_clear(2); din2 = 16'h1234;
        cas_pulse(); chk("sh_w1_b0", 32'(vd2), 32'hA5);
        cas_pulse(); chk("sh_w1_b1", 32'(vd2), 32'h34);

        // 5. Blanking with de=0, then recovery
        cpu_clear(2); de = 1'b0; din2 = 16'hFFFF;
        cas_pulse(); chk("blk_b0", 32'(vd2), 32'h12);
        cas_pulse(); chk("blk_b1", 32'(vd2), 32'h00);
        cpu_clear(2); de = 1'b1; din2 = 16'h1111;
        cas_pulse(); chk("unblk_b0", 32'(vd2), 32'h00);
        cas_pulse(); chk("unblk_b1", 32'(vd2), 32'h11);

        // 6. BYTES=4, DELAY=2
        do_reset();
        shift_en = 1'b1; de = 1'b1; din4 = 32'h4433_2211;
        cas_pulse(); chk("g_w0_b0", 32'(vd4), 32'h00);
        cas_pulse(); chk("g_w0_b1", 32'(vd4), 32'h00);
        cas_pulse(); chk("g_w0_b2", 32'(vd4), 32'h11);
        cas_pulse(); chk("g_w0_b3", 32'(vd4), 32'h22);
        cpu_clear(2); din4 = 32'h8877_6655;
        cas_pulse(); chk("g_w1_b0", 32'(vd4), 32'h33);
        cas_pulse(); chk("g_w1_b1", 32'(vd4), 32'h44);
        cas_pulse(); chk("g_w1_b2", 32'(vd4), 32'h55);
        cas_pulse(); chk("g_w1_b3", 32'(vd4), 32'h66);
        ras_n = 1'b1;
        s0 = st_cnt4;
        cas_pulse();
        chk("ras_hi_no_strobe", 32'(st_cnt4 - s0), 32'd0);
        chk("ras_hi_hold", 32'(vd4), 32'h66);
        ras_n = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
